// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline sequencing for load-use bubbles, memory stalls, branch squash and HALT drain.
module hazard_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [2:0]  id_rs,
  input  logic        id_rs_used,
  input  logic [2:0]  id_rt,
  input  logic        id_rt_used,
  input  logic        id_halt,
  input  logic [2:0]  ex_writeReg,
  input  logic        ex_regWrite,
  input  logic        ex_memRead,
  input  logic        ex_branch_taken,
  input  logic        imem_stall,
  input  logic        dmem_stall,
  output logic        pc_en,
  output logic        if_id_en,
  output logic        id_ex_en,
  output logic        ex_mem_en,
  output logic        mem_wb_en,
  output logic        if_id_flush,
  output logic        id_ex_bubble,
  output logic        halted,
  output logic [15:0] stall_cycles,
  output logic        err
);
  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;
  state_t      state_q, state_d;
  logic [1:0]  drain_cnt_q, drain_cnt_d;
  logic [15:0] stall_q, stall_d;
  logic        err_q, err_d;
  logic        lu, stall_inc;
  assign lu = id_valid & ex_memRead & ex_regWrite &
              ((id_rs_used & (id_rs == ex_writeReg)) | (id_rt_used & (id_rt == ex_writeReg)));
  always_comb begin
    {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = 5'b11111;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    stall_inc    = 1'b0;
    state_d      = state_q;
    drain_cnt_d  = drain_cnt_q;
    case (state_q)
      RUN: begin
        if (dmem_stall) begin
          {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = 5'b00000;
          stall_inc = 1'b1;
        end else if (ex_branch_taken) begin
          if_id_flush  = 1'b1;
          id_ex_bubble = 1'b1;
        end else if (lu) begin
          pc_en        = 1'b0;
          if_id_en     = 1'b0;
          id_ex_bubble = 1'b1;
          stall_inc    = 1'b1;
        end else if (id_valid & id_halt) begin
          pc_en       = 1'b0;
          if_id_flush = 1'b1;
          state_d     = DRAIN;
          drain_cnt_d = 2'd3;
        end else if (imem_stall) begin
          pc_en       = 1'b0;
          if_id_flush = 1'b1;
          stall_inc   = 1'b1;
        end
      end
      DRAIN: begin
        pc_en        = 1'b0;
        if_id_en     = 1'b0;
        id_ex_bubble = 1'b1;
        {id_ex_en, ex_mem_en, mem_wb_en} = dmem_stall ? 3'b000 : 3'b111;
        drain_cnt_d  = dmem_stall ? drain_cnt_q : drain_cnt_q - 2'd1;
        state_d      = (!dmem_stall && drain_cnt_q == 2'd1) ? HALTED : DRAIN;
      end
      default: {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = 5'b00000;
    endcase
    stall_d = (stall_inc && stall_q != 16'hFFFF) ? stall_q + 16'd1 : stall_q;
    err_d   = err_q | (ex_branch_taken & (state_q != RUN));
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= RUN;
      drain_cnt_q <= 2'd0;
      stall_q     <= 16'd0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      stall_q     <= stall_d;
      err_q       <= err_d;
    end
  end
  assign halted       = state_q == HALTED;
  assign stall_cycles = stall_q;
  assign err          = err_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed and randomized checks of hazard_ctrl against a rule-level model.
module tb_hazard_ctrl;
  logic clk = 1'b0, rst = 1'b0;
  logic id_valid, id_rs_used, id_rt_used, id_halt, ex_regWrite, ex_memRead, ex_branch_taken;
  logic imem_stall, dmem_stall;
  logic [2:0] id_rs, id_rt, ex_writeReg;
  logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_bubble, halted, err;
  logic [15:0] stall_cycles;
  int checks = 0, errors = 0;
  int mode = 0, rem = 0, sc = 0, n;
  bit merr = 0;

  hazard_ctrl dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rs_used(id_rs_used),
    .id_rt(id_rt), .id_rt_used(id_rt_used), .id_halt(id_halt), .ex_writeReg(ex_writeReg),
    .ex_regWrite(ex_regWrite), .ex_memRead(ex_memRead), .ex_branch_taken(ex_branch_taken),
    .imem_stall(imem_stall), .dmem_stall(dmem_stall), .pc_en(pc_en), .if_id_en(if_id_en),
    .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en), .if_id_flush(if_id_flush),
    .id_ex_bubble(id_ex_bubble), .halted(halted), .stall_cycles(stall_cycles), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Expected {pc,if_id,id_ex,ex_mem,mem_wb,flush,bubble}; mode 0=RUN 1=DRAIN 2=HALTED.
  task automatic model(output logic [6:0] o, output bit inc, output bit go);
    bit hz;
    hz = id_valid && ex_memRead && ex_regWrite &&
         ((id_rs_used && id_rs == ex_writeReg) || (id_rt_used && id_rt == ex_writeReg));
    inc = 0;
    go  = 0;
    if (mode == 0) begin
      if (dmem_stall)                 begin o = 7'b0000000; inc = 1; end
      else if (ex_branch_taken)       o = 7'b1111111;
      else if (hz)                    begin o = 7'b0011101; inc = 1; end
      else if (id_valid && id_halt)   begin o = 7'b0111110; go = 1; end
      else if (imem_stall)            begin o = 7'b0111110; inc = 1; end
      else                            o = 7'b1111100;
    end else if (mode == 1) o = dmem_stall ? 7'b0000001 : 7'b0011101;
    else o = 7'b0000000;
  endtask

  task automatic check_all();
    logic [6:0] o;
    bit inc, go;
    model(o, inc, go);
    chk("outs", {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_bubble}, o);
    chk("stall_cycles", stall_cycles, sc);
    chk("halted", halted, mode == 2);
    chk("err", err, merr);
  endtask

  // Called just after a falling edge with inputs applied; returns at the next falling edge.
  task automatic step();
    logic [6:0] o;
    bit inc, go;
    #1;
    check_all();
    model(o, inc, go);
    @(posedge clk);
    if (mode != 0 && ex_branch_taken) merr = 1;
    if (inc && sc < 65535) sc++;
    if (go) begin mode = 1; rem = 3; end
    else if (mode == 1 && !dmem_stall) begin rem--; if (rem == 0) mode = 2; end
    @(negedge clk);
  endtask

  task automatic async_reset();
    #2 rst = 1'b0;
    mode = 0; rem = 0; sc = 0; merr = 0;
    #1 check_all();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic idle();
    {id_valid, id_rs_used, id_rt_used, id_halt, ex_regWrite, ex_memRead, ex_branch_taken} = '0;
    {imem_stall, dmem_stall} = '0;
    id_rs = '0; id_rt = '0; ex_writeReg = '0;
  endtask

  task automatic set_lu();
    idle();
    id_valid = 1; id_rs = 3; id_rs_used = 1; id_rt = 5;
    ex_memRead = 1; ex_regWrite = 1; ex_writeReg = 3;
  endtask

  task automatic rand_in();
    id_valid        = $urandom_range(0, 3) != 0;
    id_rs           = 3'($urandom_range(0, 3));
    id_rt           = 3'($urandom_range(0, 3));
    ex_writeReg     = 3'($urandom_range(0, 3));
    id_rs_used      = $urandom_range(0, 1) == 1;
    id_rt_used      = $urandom_range(0, 1) == 1;
    id_halt         = $urandom_range(0, 15) == 0;
    ex_regWrite     = $urandom_range(0, 3) != 0;
    ex_memRead      = $urandom_range(0, 1) == 1;
    ex_branch_taken = $urandom_range(0, 7) == 0;
    imem_stall      = $urandom_range(0, 3) == 0;
    dmem_stall      = $urandom_range(0, 4) == 0;
  endtask

  initial begin
    idle();
    repeat (2) @(negedge clk);
    #1 check_all();
    @(negedge clk);
    rst = 1'b1;
    step();
    set_lu(); step();
    chk("lu_count", stall_cycles, 1);
    ex_memRead = 0; step();
    set_lu(); ex_branch_taken = 1; step();
    chk("br_over_lu", stall_cycles, 1);
    set_lu(); dmem_stall = 1;
    repeat (5) step();
    dmem_stall = 0; step();
    ex_memRead = 0; step();
    chk("dmem_freeze", stall_cycles, 7);
    idle(); id_valid = 1; id_halt = 1; ex_branch_taken = 1; step();
    chk("br_over_halt", halted, 0);
    idle(); imem_stall = 1; ex_branch_taken = 1; step();
    idle(); id_valid = 1; id_halt = 1; step();
    idle(); n = 1;
    for (int k = 0; k < 10 && !halted; k++) begin
      dmem_stall = (k == 1 || k == 2);
      step();
      n++;
    end
    chk("halt_latency", n, 6);
    idle(); step();
    ex_branch_taken = 1; step();
    idle(); step();
    async_reset();
    idle(); imem_stall = 1; step();
    idle(); id_valid = 1; id_halt = 1; step();
    idle(); ex_branch_taken = 1; step();
    idle(); step();
    async_reset();
    set_lu(); step();
    idle(); step();
    for (int i = 0; i < 3000; i++) begin
      rand_in();
      step();
      if ((mode == 2 && $urandom_range(0, 3) == 0) || $urandom_range(0, 299) == 0) async_reset();
    end
    async_reset();
    idle(); imem_stall = 1;
    for (int i = 0; i < 70000; i++) step();
    chk("saturated", stall_cycles, 16'hFFFF);
    idle(); step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
